// File: rtl/rc_pkg.sv
// Shared types, widths and helpers for the LCU rate controller.
package rc_pkg;

    localparam int unsigned QP_W  = 6;
    localparam int unsigned QP_IW = 8;
    localparam int unsigned THR_W = 16;
    localparam int unsigned LVL_W = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACC,
        ST_PRED,
        ST_CMP,
        ST_LVL,
        ST_QP,
        ST_ROI,
        ST_CLIP,
        ST_DONE
    } rc_state_e;

    // Unsigned add clamped to 2^w-1 (w <= 63).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] s;
        logic [64:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (65'd1 << w) - 65'd1;
        return (s > m) ? m[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/rc_roi_match.sv
// Combinational test of one CTU position against one ROI rectangle.
module rc_roi_match #(
    parameter int unsigned X_W = 7,
    parameter int unsigned Y_W = 6
) (
    input  logic [X_W-1:0] ctu_x,
    input  logic [Y_W-1:0] ctu_y,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    input  logic           en,
    output logic           hit
);

    logic [X_W:0] x_end;
    logic [Y_W:0] y_end;

    // Exclusive upper bounds, one bit wider so a rectangle at the edge cannot wrap.
    assign x_end = {1'b0, x} + {1'b0, w};
    assign y_end = {1'b0, y} + {1'b0, h};

    assign hit = en
               && ({1'b0, ctu_x} >= {1'b0, x}) && ({1'b0, ctu_x} < x_end)
               && ({1'b0, ctu_y} >= {1'b0, y}) && ({1'b0, ctu_y} < y_end);

endmodule

// File: rtl/rc_lcu_qp_ctrl.sv
// LCU rate controller: accumulate cost/bits, predict, grade error, derive and clip QP.
// Build option: define RC_ROI_EN to enable ROI QP offsets.
module rc_lcu_qp_ctrl
    import rc_pkg::*;
#(
    parameter int unsigned COST_W   = 28,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned K_W      = 16,
    parameter int unsigned K_SHIFT  = 28,
    parameter int unsigned PRED_DLY = 6,
    parameter int unsigned NUM_LVL  = 4,
    parameter int unsigned NUM_ROI  = 2,
    parameter int unsigned X_W      = 7,
    parameter int unsigned Y_W      = 6
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     frame_start_i,
    input  logic                     rc_start_i,
    output logic                     rc_busy_o,
    output logic                     rc_done_o,
    input  logic [X_W-1:0]           rc_ctu_x_i,
    input  logic [Y_W-1:0]           rc_ctu_y_i,
    input  logic [15:0]              actual_bitnum_i,
    input  logic [COST_W-1:0]        cost_i,
    input  logic [K_W-1:0]           reg_k_i,
    input  logic [NUM_LVL*THR_W-1:0] reg_lvl_thr_i,
    input  logic                     reg_lcu_rc_en_i,
    input  logic [QP_W-1:0]          reg_init_qp_i,
    input  logic [QP_W-1:0]          reg_min_qp_i,
    input  logic [QP_W-1:0]          reg_max_qp_i,
    input  logic [NUM_ROI-1:0]       reg_roi_en_i,
    input  logic [NUM_ROI*X_W-1:0]   reg_roi_x_i,
    input  logic [NUM_ROI*X_W-1:0]   reg_roi_w_i,
    input  logic [NUM_ROI*Y_W-1:0]   reg_roi_y_i,
    input  logic [NUM_ROI*Y_W-1:0]   reg_roi_h_i,
    input  logic [NUM_ROI*QP_W-1:0]  reg_roi_dqp_i,
    output logic [QP_W-1:0]          rc_qp_o,
    output logic [ACC_W-1:0]         cost_sum_o,
    output logic [ACC_W-1:0]         pred_bit_o
);

    localparam int unsigned P_W = ACC_W + K_W;

    rc_state_e               state_q, state_d;
    logic                    busy_d, done_d;
    logic [ACC_W-1:0]        cost_sum_q, frame_bit_q, pred_q, diff_q;
    logic [ACC_W-1:0]        dly_q [PRED_DLY];
    logic [ACC_W-1:0]        sum_c, bit_c, pred_c;
    logic [P_W-1:0]          prod_c, prod_sh_c;
    logic                    over_q, clr_pend_q, clr_c;
    logic [LVL_W-1:0]        lvl_q, lvl_c;
    logic signed [QP_IW-1:0] qp_q, qp_c, roi_qp_c, clip_c;
    logic signed [QP_IW-1:0] init_s, min_s, max_s, lvl_s;

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (rc_start_i) state_d = ST_ACC;
            ST_ACC:  state_d = ST_PRED;
            ST_PRED: state_d = ST_CMP;
            ST_CMP:  state_d = ST_LVL;
            ST_LVL:  state_d = ST_QP;
            ST_QP:   state_d = ST_ROI;
            ST_ROI:  state_d = ST_CLIP;
            ST_CLIP: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State register with busy/done flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            rc_busy_o <= 1'b0;
            rc_done_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            rc_busy_o <= busy_d;
            rc_done_o <= done_d;
        end
    end

    // Frame clear: immediate when idle, deferred to the end of a running update.
    assign clr_c = ((state_q == ST_IDLE) && frame_start_i)
                || ((state_q == ST_DONE) && (clr_pend_q || frame_start_i));

    assign sum_c = ACC_W'(sat_add(64'(cost_sum_q), 64'(cost_i), ACC_W));
    assign bit_c = ACC_W'(sat_add(64'(frame_bit_q), 64'(actual_bitnum_i), ACC_W));

    // Accumulators, cost delay line and pending frame-clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cost_sum_q  <= '0;
            frame_bit_q <= '0;
            clr_pend_q  <= 1'b0;
            for (int i = 0; i < int'(PRED_DLY); i++) dly_q[i] <= '0;
        end else begin
            if (clr_c) begin
                cost_sum_q  <= '0;
                frame_bit_q <= '0;
                for (int i = 0; i < int'(PRED_DLY); i++) dly_q[i] <= '0;
            end else if (state_q == ST_ACC) begin
                cost_sum_q  <= sum_c;
                frame_bit_q <= bit_c;
                dly_q[0]    <= sum_c;
                for (int i = 1; i < int'(PRED_DLY); i++) dly_q[i] <= dly_q[i-1];
            end
            if (state_q == ST_DONE)
                clr_pend_q <= 1'b0;
            else if ((state_q != ST_IDLE) && frame_start_i)
                clr_pend_q <= 1'b1;
        end
    end

    // Prediction from the delayed cost, clamped to the accumulator width.
    always_comb begin
        prod_c    = P_W'(dly_q[PRED_DLY-1]) * P_W'(reg_k_i);
        prod_sh_c = prod_c >> K_SHIFT;
        pred_c    = (|prod_sh_c[P_W-1:ACC_W]) ? '1 : prod_sh_c[ACC_W-1:0];
    end

    // Error level: count of thresholds strictly below the error magnitude.
    always_comb begin
        lvl_c = '0;
        for (int i = 0; i < int'(NUM_LVL); i++)
            if (ACC_W'(reg_lvl_thr_i[i*THR_W +: THR_W]) < diff_q) lvl_c = lvl_c + LVL_W'(1);
    end

    assign init_s = $signed(QP_IW'(reg_init_qp_i));
    assign min_s  = $signed(QP_IW'(reg_min_qp_i));
    assign max_s  = $signed(QP_IW'(reg_max_qp_i));
    assign lvl_s  = $signed(QP_IW'(lvl_q));

    // Base QP: follow the error grade except when disabled or on the first CTU row.
    always_comb begin
        qp_c = init_s;
        if (reg_lcu_rc_en_i && (rc_ctu_y_i != '0))
            qp_c = over_q ? (init_s + lvl_s) : (init_s - lvl_s);
    end

`ifdef RC_ROI_EN
    logic [NUM_ROI-1:0]      roi_hit;
    logic signed [QP_IW-1:0] dqp_s [NUM_ROI];

    for (genvar n = 0; n < int'(NUM_ROI); n++) begin : g_roi
        rc_roi_match #(.X_W(X_W), .Y_W(Y_W)) u_match (
            .ctu_x (rc_ctu_x_i),
            .ctu_y (rc_ctu_y_i),
            .x     (reg_roi_x_i[n*X_W +: X_W]),
            .y     (reg_roi_y_i[n*Y_W +: Y_W]),
            .w     (reg_roi_w_i[n*X_W +: X_W]),
            .h     (reg_roi_h_i[n*Y_W +: Y_W]),
            .en    (reg_roi_en_i[n]),
            .hit   (roi_hit[n])
        );
        assign dqp_s[n] = $signed({{(QP_IW-QP_W){reg_roi_dqp_i[n*QP_W+QP_W-1]}},
                                   reg_roi_dqp_i[n*QP_W +: QP_W]});
    end

    // Lowest-index matching ROI wins; scan high to low so it is applied last.
    always_comb begin
        roi_qp_c = qp_q;
        for (int n = int'(NUM_ROI) - 1; n >= 0; n--)
            if (roi_hit[n]) roi_qp_c = qp_q - dqp_s[n];
    end
`else
    logic unused_roi;
    assign unused_roi = ^{reg_roi_en_i, reg_roi_x_i, reg_roi_w_i, reg_roi_y_i,
                          reg_roi_h_i, reg_roi_dqp_i, rc_ctu_x_i};
    assign roi_qp_c   = qp_q;
`endif

    // Clip in signed space; an inverted range resolves to min.
    always_comb begin
        clip_c = qp_q;
        if ((min_s > max_s) || (qp_q < min_s)) clip_c = min_s;
        else if (qp_q > max_s)                 clip_c = max_s;
    end

    // One pipeline step per FSM state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pred_q  <= '0;
            over_q  <= 1'b0;
            diff_q  <= '0;
            lvl_q   <= '0;
            qp_q    <= '0;
            rc_qp_o <= '0;
        end else begin
            case (state_q)
                ST_PRED: pred_q <= pred_c;
                ST_CMP: begin
                    over_q <= (frame_bit_q > pred_q);
                    diff_q <= (frame_bit_q > pred_q) ? (frame_bit_q - pred_q)
                                                     : (pred_q - frame_bit_q);
                end
                ST_LVL:  lvl_q   <= lvl_c;
                ST_QP:   qp_q    <= qp_c;
                ST_ROI:  qp_q    <= roi_qp_c;
                ST_CLIP: rc_qp_o <= clip_c[QP_W-1:0];
                default: ;
            endcase
        end
    end

    assign cost_sum_o = cost_sum_q;
    assign pred_bit_o = pred_q;

endmodule

// File: doc/rc_lcu_qp_ctrl.md
# rc_lcu_qp_ctrl

Parametrised LCU-level rate controller: per CTU, accumulates actual CABAC bits and pre-intra best-mode cost, predicts the expected bit count from cost delayed by `PRED_DLY` CTUs, and grades the actual-vs-predicted error against `NUM_LVL` thresholds. It then derives a QP with signed multi-region ROI offsets and clips it. It sits between pre_i (cost) / CABAC (bits) and the CTU-level QP consumers. It is the multi-level, multi-ROI, saturating, frame-resettable successor to the fixed 10-cycle LCU controller.

## Interface
- `COST_W`, default 28: per-CTU cost input width.
- `ACC_W`, default 32: cost and bit accumulator width; accumulators saturate.
- `K_W`, default 16: gain `reg_k_i` width.
- `K_SHIFT`, default 28: right shift applied to the prediction product.
- `PRED_DLY`, default 6: cost delay-line depth in CTUs, 1..15.
- `NUM_LVL`, default 4: number of error thresholds, 1..7.
- `NUM_ROI`, default 2: number of ROI rectangles, 1..4.
- `X_W` / `Y_W`, defaults 7 / 6: CTU coordinate widths.
- Ports:
  - `clk`  in  1  clock.
  - `rstn`  in  1  async active-low reset.
  - `frame_start_i`  in  1  pulse; clears accumulators and the delay line.
  - `rc_start_i`  in  1  pulse; start one CTU update.
  - `rc_busy_o`  out  1  high from the cycle after an accepted start through DONE.
  - `rc_done_o`  out  1  one-cycle pulse; `rc_qp_o` is valid from this cycle onward.
  - `rc_ctu_x_i` / `rc_ctu_y_i`  in  X_W / Y_W  current CTU position.
  - `actual_bitnum_i`  in  16  bits of the previous CTU.
  - `cost_i`  in  COST_W  pre_i best-mode cost.
  - `reg_k_i`  in  K_W  prediction gain.
  - `reg_lvl_thr_i`  in  NUM_LVL*16  ascending thresholds; index 0 in the LSBs.
  - `reg_lcu_rc_en_i`  in  1  rate-control enable.
  - `reg_init_qp_i` / `reg_min_qp_i` / `reg_max_qp_i`  in  6 each.
  - `reg_roi_en_i`  in  NUM_ROI  per-ROI enable.
  - `reg_roi_x_i` / `reg_roi_w_i`  in  NUM_ROI*X_W.
  - `reg_roi_y_i` / `reg_roi_h_i`  in  NUM_ROI*Y_W.
  - `reg_roi_dqp_i`  in  NUM_ROI*6  signed two's-complement QP offset.
  - `rc_qp_o`  out  6  clipped QP.
  - `cost_sum_o`  out  ACC_W  saturated frame cost sum.
  - `pred_bit_o`  out  ACC_W  last prediction.

## Operation
- FSM states: IDLE, ACC, PRED, CMP, LVL, QP, ROI, CLIP, DONE. Every state lasts one cycle; DONE returns to IDLE.
- `rc_start_i` is accepted only in IDLE and ignored otherwise.
- ACC:
  - `cost_sum += cost_i` and `frame_bit += actual_bitnum_i`, both saturating at 2^ACC_W-1.
  - The delay line shifts in the updated `cost_sum`.
- PRED: `pred = (dly[PRED_DLY-1]*reg_k_i) >> K_SHIFT`, saturated to ACC_W bits.
- CMP: `over = frame_bit > pred`; `diff = |frame_bit - pred|`.
- LVL: `level` = number of thresholds strictly below `diff` (0..NUM_LVL). Thresholds are used as given; order is not checked.
- QP: computed in signed 8-bit. `qp = init` if `!reg_lcu_rc_en_i` or `rc_ctu_y_i==0`; else `init + level` when `over`, `init - level` otherwise.
- ROI:
  - A CTU hits ROI n if `reg_roi_en_i[n]`, `x <= ctu_x < x+w`, and `y <= ctu_y < y+h`. Bounds are compared one bit wider so they do not wrap.
  - The lowest-index hit applies `qp -= dqp[n]`; otherwise qp is unchanged.
- CLIP:
  - qp below min gives min.
  - Otherwise qp above max gives max.
  - If min > max, min wins.
  - Negative intermediate values clip to min; there is no 6-bit wrap.
- `frame_start_i`:
  - In IDLE, it clears `cost_sum`, `frame_bit` and the delay line in the same cycle.
  - If it arrives together with `rc_start_i`, the clear happens first and ACC adds onto zero.
  - If it arrives while busy, it is latched and applied on the DONE→IDLE transition.

## Timing
- Start accepted at cycle 0 → DONE, with `rc_done_o=1` and `rc_qp_o` updated, at cycle 8. The next start is accepted at cycle 9 or later.
- `cost_sum_o` updates at cycle 2 and `pred_bit_o` at cycle 3.
- Inputs (`cost_i`, `actual_bitnum_i`, coordinates, `reg_*`) must be held stable from cycle 0 through cycle 8.
- Reset values: `rc_qp_o=0`, `rc_done_o=0`, `rc_busy_o=0`, `cost_sum_o=0`, `pred_bit_o=0`. The FSM goes to IDLE and accumulators, delay line and pending frame-clear are all zero.
- Reset asserted mid-operation aborts the update; no `rc_done_o` is produced.

## Configuration
- `RC_ROI_EN` defined: ROI matching and offsets are active as described above.
- `RC_ROI_EN` undefined:
  - No ROI logic is built; ROI ports remain present but are ignored.
  - The ROI state passes qp through unchanged, so latency stays at 8 cycles.

## Structure
- Package `rc_pkg` holds:
  - the state enum;
  - `QP_W=6` and `QP_IW=8` (the internal signed QP width);
  - the threshold field width 16;
  - a saturating-add function.
- Sub-module `rc_roi_match`: one per ROI, instantiated with generate. It is purely combinational: inputs are ctu_x, ctu_y, x, y, w, h and en; output is hit.

## Test plan
- Reset mid-run: assert `rstn=0` at cycle 4 → all outputs 0, no `rc_done_o`; after release, a start produces done at +8 cycles.
- `reg_lcu_rc_en_i=0`, `init=30` → `rc_qp_o=30` with done exactly 8 cycles after start; a start issued at cycle 3 is ignored.
- `rc_ctu_y_i=1`, `frame_bit` 1000 above `pred`, thresholds {100,500,2000,4000}, `init=30`, `max=51` → `rc_qp_o=32`. With the same magnitude under-predicted → 28.
- ROI0 and ROI1 overlapping the CTU, `dqp0=+5`, `dqp1=-3`, `qp=30` → 25. With ROI0 disabled → 33. With `RC_ROI_EN` undefined → 30.
- `init=2`, `level=4`, under-predicted, `min=0` → 0, not wrapped. With `min=10`, `max=8` → 10.
- Saturation: `cost_i=2^28-1` repeatedly with ACC_W=32 → `cost_sum_o` sticks at `0xFFFFFFFF`. `frame_start_i` during busy → sum reads 0 after the next update's ACC equals `cost_i` only.
